// File: rtl/ccg_resp_misr.sv
// Output-response compactor: accepts response vectors over valid/ready, folds them into a
// Galois MISR and compares the final signature against a golden value after num_vec vectors.
module ccg_resp_misr #(
    parameter int                   RESP_W = 10,
    parameter int                   SIG_W  = 16,
    parameter int                   CNT_W  = 21,
    parameter logic [SIG_W-1:0]     POLY   = 16'h002D,
    parameter logic [SIG_W-1:0]     SEED   = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vec,
    input  logic [SIG_W-1:0]   golden,
    input  logic               resp_valid,
    input  logic [RESP_W-1:0]  resp_data,
    output logic               resp_ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [SIG_W-1:0]   signature,
    output logic [CNT_W-1:0]   vec_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [SIG_W-1:0]   sig_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   num_vec_r;
    logic [SIG_W-1:0]   golden_r;

    logic               handshake_s;
    logic [SIG_W-1:0]   next_sig_s;
    logic [CNT_W-1:0]   next_count_s;

    // One Galois MISR step: shift left, feed the MSB back through POLY, xor in the data.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [RESP_W-1:0] data);
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
        misr_step = {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(data);
    endfunction

    // Next-state datapath values for an accepted vector.
    always_comb begin
        handshake_s  = resp_valid & (state_r == ST_RUN);
        next_sig_s   = misr_step(sig_r, resp_data);
        next_count_s = count_r + CNT_W'(1);
    end

    // Run-control FSM with registered status flags and compaction datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            sig_r     <= SEED;
            count_r   <= {CNT_W{1'b0}};
            num_vec_r <= {CNT_W{1'b0}};
            golden_r  <= {SIG_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sig_r     <= SEED;
                        count_r   <= {CNT_W{1'b0}};
                        num_vec_r <= num_vec;
                        golden_r  <= golden;
                        if (num_vec != {CNT_W{1'b0}}) begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                            pass_r  <= 1'b0;
                        end else begin
                            // Empty run: the seed itself is the final signature.
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (SEED == golden);
                        end
                    end
                end
                ST_RUN: begin
                    if (handshake_s) begin
                        sig_r   <= next_sig_s;
                        count_r <= next_count_s;
                        if (next_count_s == num_vec_r) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (next_sig_s == golden_r);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign resp_ready = (state_r == ST_RUN);
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign signature  = sig_r;
    assign vec_count  = count_r;

endmodule

// File: tb/tb_ccg_resp_misr.sv
// Self-checking bench for ccg_resp_misr: directed scenarios plus randomized runs
// checked against an arithmetic polynomial-division model of the MISR.
module tb_ccg_resp_misr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [20:0] num_vec = 21'd0;
    logic [15:0] golden = 16'h0000;
    logic        resp_valid = 1'b0;
    logic [9:0]  resp_data = 10'h000;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [20:0] vec_count;

    int tests_run = 0;
    int tests_failed = 0;

    ccg_resp_misr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_vec    (num_vec),
        .golden     (golden),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .vec_count  (vec_count)
    );

    always #5 clk = ~clk;

    // Signature as a polynomial over GF(2): multiply by x, reduce modulo x^16+x^5+x^3+x^2+1, add data.
    function automatic int unsigned model_step(input int unsigned s, input int unsigned d);
        int unsigned t;
        t = s * 2;
        if (t >= 32'h10000) t = (t - 32'h10000) ^ 32'h2D;
        return t ^ d;
    endfunction

    task automatic do_start(input int unsigned n, input int unsigned g);
        @(negedge clk);
        start = 1'b1; num_vec = n[20:0]; golden = g[15:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_vec(input int unsigned d);
        resp_valid = 1'b1; resp_data = d[9:0];
        @(negedge clk);
        resp_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_start(3, 16'h0);
        send_vec(10'h155);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, pass, resp_ready} !== 4'b0000 || signature !== 16'hFFFF || vec_count !== 21'd0) begin
            tests_failed++;
            $display("FAIL reset: busy/done/pass/ready=%b sig=%h cnt=%0d, need 0000 FFFF 0",
                     {busy, done, pass, resp_ready}, signature, vec_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single(input int unsigned d, input int unsigned exp_sig, input string name);
        do_start(1, exp_sig);
        tests_run++;
        if (busy !== 1'b1 || resp_ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_run: busy=%b ready=%b done=%b, need 1 1 0", name, busy, resp_ready, done);
        end
        send_vec(d);
        tests_run++;
        if (done !== 1'b1 || signature !== exp_sig[15:0] || pass !== 1'b1 || vec_count !== 21'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: done=%b sig=%h pass=%b cnt=%0d busy=%b, need 1 %h 1 1 0",
                     name, done, signature, pass, vec_count, busy, exp_sig[15:0]);
        end
    endtask

    task automatic test_gaps;
        do_start(2, 16'h1234);
        send_vec(10'h000);
        repeat (3) begin
            resp_data = 10'h3A5;
            @(negedge clk);
            tests_run++;
            if (signature !== 16'hFFD3 || vec_count !== 21'd1 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL gap_hold: sig=%h cnt=%0d done=%b, need FFD3 1 0", signature, vec_count, done);
            end
        end
        send_vec(10'h000);
        tests_run++;
        if (done !== 1'b1 || signature !== 16'hFF8B || pass !== 1'b0 || vec_count !== 21'd2) begin
            tests_failed++;
            $display("FAIL gaps: done=%b sig=%h pass=%b cnt=%0d, need 1 FF8B 0 2", done, signature, pass, vec_count);
        end
    endtask

    task automatic test_zero_count;
        do_start(0, 16'hFFFF);
        tests_run++;
        if (done !== 1'b1 || pass !== 1'b1 || resp_ready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_count: done=%b pass=%b ready=%b busy=%b, need 1 1 0 0", done, pass, resp_ready, busy);
        end
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1; resp_data = 10'h2C3;
            #1;
            tests_run++;
            if (resp_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_ready: ready=%b, need 0", resp_ready);
            end
            @(negedge clk);
        end
        resp_valid = 1'b0;
        tests_run++;
        if (signature !== 16'hFFFF || vec_count !== 21'd0 || done !== 1'b1 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_ignore: sig=%h cnt=%0d done=%b pass=%b, need FFFF 0 1 1", signature, vec_count, done, pass);
        end
    endtask

    task automatic test_reset_midrun;
        do_start(4, 16'h0);
        send_vec(10'h0F0);
        send_vec(10'h00F);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, pass, resp_ready} !== 4'b0000 || signature !== 16'hFFFF || vec_count !== 21'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset: flags=%b sig=%h cnt=%0d, need 0000 FFFF 0",
                     {busy, done, pass, resp_ready}, signature, vec_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1, 16'hFFD3);
        start = 1'b1; num_vec = 21'd7; golden = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        send_vec(10'h000);
        tests_run++;
        if (done !== 1'b1 || signature !== 16'hFFD3 || pass !== 1'b1 || vec_count !== 21'd1) begin
            tests_failed++;
            $display("FAIL start_ignored: done=%b sig=%h pass=%b cnt=%0d, need 1 FFD3 1 1", done, signature, pass, vec_count);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 10; r++) begin
            int unsigned n, g, exp_sig, d;
            n = $urandom_range(1, 24);
            exp_sig = 32'hFFFF;
            g = $urandom_range(0, 16'hFFFF);
            do_start(n, g);
            for (int i = 0; i < int'(n); i++) begin
                int unsigned gap;
                gap = $urandom_range(0, 3);
                for (int k = 0; k < int'(gap); k++) begin
                    start = ($urandom_range(0, 3) == 0);
                    num_vec = 21'($urandom_range(0, 100));
                    golden = 16'($urandom);
                    resp_data = 10'($urandom);
                    @(negedge clk);
                    start = 1'b0;
                end
                d = $urandom_range(0, 10'h3FF);
                exp_sig = model_step(exp_sig, d);
                send_vec(d);
                tests_run++;
                if (vec_count !== 21'(i + 1) || done !== (i + 1 == int'(n))) begin
                    tests_failed++;
                    $display("FAIL rand_progress: run=%0d cnt=%0d done=%b, need %0d %b",
                             r, vec_count, done, i + 1, (i + 1 == int'(n)));
                end
            end
            // Re-run with a golden that must match on odd runs to exercise pass=1.
            tests_run++;
            if (signature !== exp_sig[15:0] || pass !== (g[15:0] == exp_sig[15:0]) || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_final: run=%0d sig=%h pass=%b busy=%b, need %h %b 0",
                         r, signature, pass, busy, exp_sig[15:0], (g[15:0] == exp_sig[15:0]));
            end
            if (r % 2 == 1) begin
                int unsigned s2;
                s2 = 32'hFFFF;
                d = $urandom_range(0, 10'h3FF);
                s2 = model_step(s2, d);
                do_start(1, s2);
                send_vec(d);
                tests_run++;
                if (pass !== 1'b1 || signature !== s2[15:0]) begin
                    tests_failed++;
                    $display("FAIL rand_match: sig=%h pass=%b, need %h 1", signature, pass, s2[15:0]);
                end
            end
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        test_reset;
        test_single(10'h000, 16'hFFD3, "single_zero");
        test_single(10'h3FF, 16'hFC2C, "single_ones");
        test_gaps;
        test_zero_count;
        test_reset_midrun;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
